// File: rtl/mux_result_fifo.sv
// Two-entry FIFO buffering mux results {sel, data} between an upstream mux and a
// downstream consumer, with a sticky overflow flag for words offered while full.
module mux_result_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sel,
  input  logic             out_ready,
  output logic [1:0]       count,
  output logic             ovf
);

  localparam int EW = WIDTH + 1;

  // Handshake: a word moves on a rising edge only when valid && ready on that side;
  // in_ready depends on registered count alone, so out_ready never reaches it.
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          do_wr, do_rd;

  assign in_ready  = (count_q != 2'(DEPTH));
  assign out_valid = (count_q != 2'd0);
  assign {out_sel, out_data} = mem_q[rd_ptr_q];
  assign count = count_q;
  assign ovf   = ovf_q;

  always_comb begin
    do_wr    = in_valid && in_ready;
    do_rd    = out_valid && out_ready;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q || (in_valid && !in_ready);
    if (do_wr) begin
      mem_d[wr_ptr_q] = {in_sel, in_data};
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_rd) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      ovf_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mux_result_fifo.sv
// Directed bench for mux_result_fifo: reset, single pass, fill/overflow,
// simultaneous read/write, mux-result sweep with random drain, mid-run reset.
module tb_mux_result_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] in_data;
  logic       in_sel;
  logic       in_ready;
  logic       out_valid;
  logic [1:0] out_data;
  logic       out_sel;
  logic       out_ready;
  logic [1:0] count;
  logic       ovf;

  int checks   = 0;
  int failures = 0;

  logic [2:0] exp_q[$];
  logic [2:0] stim [32];
  logic [2:0] head;

  mux_result_fifo #(.WIDTH(2), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_sel(in_sel), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel), .out_ready(out_ready),
    .count(count), .ovf(ovf)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver
  task automatic drive(input logic v, input logic s, input logic [1:0] d, input logic r);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
  endtask

  initial begin
    int idx;
    int cycles;

    // Reset held two cycles with in_valid asserted
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 2'b11, 1'b1);
    tick();
    tick();
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_ovf", ovf, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sel", out_sel, 0);

    // Single pass: no bypass before the edge, visible after it
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 2'b10, 1'b0);
    chk("pass_no_bypass", out_valid, 0);
    tick();
    drive(1'b0, 1'b0, 2'b00, 1'b0);
    chk("pass_out_valid", out_valid, 1);
    chk("pass_out_data", out_data, 2'b10);
    chk("pass_out_sel", out_sel, 1);
    chk("pass_count", count, 1);
    tick();
    chk("pass_hold_data", out_data, 2'b10);
    chk("pass_hold_count", count, 1);
    out_ready = 1'b1;
    tick();
    chk("pass_drained", count, 0);
    tick();
    chk("empty_read_count", count, 0);
    chk("empty_read_valid", out_valid, 0);

    // Fill then overflow
    drive(1'b1, 1'b0, 2'b01, 1'b0);
    tick();
    drive(1'b1, 1'b1, 2'b11, 1'b0);
    tick();
    chk("fill_count", count, 2);
    chk("fill_in_ready", in_ready, 0);
    chk("fill_ovf_clear", ovf, 0);
    drive(1'b1, 1'b0, 2'b00, 1'b0);
    tick();
    chk("ovf_set", ovf, 1);
    chk("ovf_count", count, 2);
    drive(1'b0, 1'b0, 2'b00, 1'b1);
    chk("ovf_head0", {out_sel, out_data}, 3'b001);
    tick();
    chk("ovf_head1", {out_sel, out_data}, 3'b111);
    chk("ovf_count1", count, 1);
    tick();
    chk("ovf_empty", out_valid, 0);
    chk("ovf_sticky", ovf, 1);

    // Reset clears the sticky flag
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("ovf_cleared", ovf, 0);

    // Simultaneous write and read at count 1
    drive(1'b1, 1'b0, 2'b01, 1'b0);
    tick();
    drive(1'b1, 1'b0, 2'b10, 1'b1);
    chk("sim_head_before", out_data, 2'b01);
    tick();
    chk("sim_count", count, 1);
    chk("sim_out_data", out_data, 2'b10);
    drive(1'b0, 1'b0, 2'b00, 1'b1);
    tick();
    chk("sim_drained", count, 0);

    // Sweep of all mux results r = s ? b : a with random drain
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 4; a++)
        for (int b = 0; b < 4; b++)
          stim[s*16 + a*4 + b] = {1'(s), (s != 0) ? 2'(b) : 2'(a)};
    idx = 0;
    cycles = 0;
    while ((idx < 32 || exp_q.size() != 0) && cycles < 1000) begin
      out_ready = 1'($urandom_range(0, 1));
      if (idx < 32 && in_ready) begin
        in_valid = 1'b1;
        {in_sel, in_data} = stim[idx];
      end else begin
        in_valid = 1'b0;
      end
      chk("sweep_valid", out_valid, exp_q.size() != 0);
      chk("sweep_in_ready", in_ready, exp_q.size() != 2);
      if (out_valid && out_ready && exp_q.size() != 0) begin
        head = exp_q.pop_front();
        chk("sweep_word", {out_sel, out_data}, head);
      end
      if (in_valid) begin
        exp_q.push_back(stim[idx]);
        idx++;
      end
      tick();
      cycles++;
    end
    chk("sweep_done", (idx == 32) && (exp_q.size() == 0), 1);
    chk("sweep_ovf", ovf, 0);

    // Reset mid-run while full
    drive(1'b1, 1'b0, 2'b01, 1'b0);
    tick();
    drive(1'b1, 1'b1, 2'b10, 1'b0);
    tick();
    chk("mid_full", count, 2);
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 2'b01, 1'b1);
    tick();
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 1'b0);
    chk("mid_count", count, 0);
    chk("mid_out_valid", out_valid, 0);
    drive(1'b1, 1'b0, 2'b11, 1'b0);
    tick();
    drive(1'b0, 1'b0, 2'b00, 1'b0);
    chk("mid_readback", out_data, 2'b11);
    chk("mid_readback_count", count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_result_fifo.md
MUX_RESULT_FIFO -- requirements
Module: mux_result_fifo

Interface
REQ-001 Parameter: WIDTH, 2, bit width of the mux result word being buffered.
REQ-002 Parameter: DEPTH, 2, number of storage entries; only value 2 is supported.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: in_valid  input  1  upstream mux result r is presented this cycle.
REQ-006 Port: in_data  input  WIDTH  mux result r.
REQ-007 Port: in_sel  input  1  select s that produced in_data; stored alongside as a tag.
REQ-008 Port: in_ready  output  1  block can accept a word this cycle.
REQ-009 Port: out_valid  output  1  head entry available to downstream.
REQ-010 Port: out_data  output  WIDTH  head entry data.
REQ-011 Port: out_sel  output  1  head entry select tag.
REQ-012 Port: out_ready  input  1  downstream consumes head when out_valid is high.
REQ-013 Port: count  output  2  occupancy, 0..2.
REQ-014 Port: ovf  output  1  sticky overflow flag.

Function
REQ-015 Write occurs at clk edge when in_valid && in_ready; {in_sel,in_data} is stored at the write pointer and the write pointer advances.
REQ-016 Read occurs at clk edge when out_valid && out_ready; the read pointer advances.
REQ-017 Write and read pointers are 1 bit each and wrap from 1 to 0.
REQ-018 in_ready = (count != 2); it is derived from registered count only, with no combinational path from out_ready.
REQ-019 out_valid = (count != 0); out_data/out_sel come from the entry at the read pointer.
REQ-020 out_data and out_sel hold their value while out_valid && !out_ready.
REQ-021 Latency: a word accepted at edge N is visible on out_valid/out_data after edge N; there is no same-cycle bypass.
REQ-022 count update per edge: write only +1; read only -1; both or neither unchanged.
REQ-023 Simultaneous write and read at count 1: count stays 1, the new word becomes head after the read, and order is preserved.
REQ-024 At count 2 no write occurs; a read the same cycle frees a slot usable from the next cycle only.
REQ-025 At count 0, out_ready has no effect and the read pointer does not move.
REQ-026 ovf is set at the edge where in_valid && !in_ready, stays set until reset, and the offered word is dropped.
REQ-027 Words leave in strict FIFO order; the tag always accompanies its own data.

Reset
REQ-028 When rst_n=0 at a clk edge: count=0, both pointers=0, ovf=0, storage cleared to 0; thus out_valid=0, out_data=0, out_sel=0, in_ready=1.
REQ-029 Reset mid-operation discards all stored words; no read or write is performed at a reset edge regardless of in_valid/out_ready.
REQ-030 No state change occurs without a clk edge.

Verification
REQ-031 Reset: hold rst_n=0 two cycles with in_valid=1 -> count=0, out_valid=0, in_ready=1, ovf=0.
REQ-032 Single pass: write in_sel=1,in_data=2'b10 with out_ready=0 -> next cycle out_valid=1,out_data=2'b10,out_sel=1,count=1; then out_ready=1 one cycle -> count=0.
REQ-033 Fill/overflow: out_ready=0, write 2'b01,2'b11,then offer 2'b00 -> count=2, in_ready=0, ovf=1, and reads yield 01 then 11 only.
REQ-034 Simultaneous: count=1 holding 2'b01, write 2'b10 and read same edge -> count=1, out_data=2'b10.
REQ-035 Exhaustive sweep: all 2 s x 4 a x 4 b combinations, with r=(s?b:a) fed as in_data/in_sel and random out_ready -> output stream equals input stream in order with matching tags, and ovf=0.
REQ-036 Reset mid-run: count=2, assert rst_n=0 one edge -> count=0, out_valid=0; the next write 2'b11 reads back as 2'b11.
